led_display_bcm_driver: RTL and testbench
=========================================

LED_DISPLAY_BCM_DRIVER -- requirements
Module: led_display_bcm_driver

Interface
REQ-001 Parameter NUM_ROW_PIXELS, default 32: panel rows; scan rows = NUM_ROW_PIXELS/2.
REQ-002 Parameter NUM_COL_PIXELS, default 64: panel columns; power of two.
REQ-003 Parameter COLOUR_DEPTH, default 8: bits per colour channel (bit planes), range 1..10.
REQ-004 Parameter BCLK_DIV, default 2: clk_in cycles per bclk half-period, >=1.
REQ-005 Parameter BASE_ON_CYCLES, default 64: display cycles for bit plane 0, >=1.
REQ-006 clk_in  input  1  system clock; all logic on rising edge.
REQ-007 n_reset_in  input  1  reset, asynchronous, active-low.
REQ-008 enable_in  input  1  level; high = scan panel continuously.
REQ-009 rd_addr_out  output  RA+CA  frame-buffer read address {scan_row, col}; RA=clog2(NUM_ROW_PIXELS/2), CA=clog2(NUM_COL_PIXELS).
REQ-010 rd_data_in  input  6*COLOUR_DEPTH  {top R,G,B, bottom R,G,B}, each COLOUR_DEPTH bits, MSB-first; valid exactly 1 cycle after rd_addr_out.
REQ-011 rgb_top_out  output  3  {B,G,R} current-plane bits, top half.
REQ-012 rgb_bot_out  output  3  {B,G,R} current-plane bits, bottom half.
REQ-013 bclk_out  output  1  panel shift clock; panel samples on rising edge.
REQ-014 latch_out  output  1  panel latch strobe, active-high.
REQ-015 oe_n_out  output  1  panel output enable, active-low.
REQ-016 row_addr_out  output  RA  scan row address.
REQ-017 frame_done_out  output  1  one-cycle pulse at end of last plane of last scan row.

Function
REQ-018 FSM states IDLE, SHIFT, LATCH, DISPLAY; IDLE->SHIFT when enable_in=1, starting row 0, plane 0, column 0.
REQ-019 SHIFT: per column, rd_addr_out issued, rgb outputs updated with bclk_out low, held BCLK_DIV cycles low then BCLK_DIV cycles high; NUM_COL_PIXELS rising bclk edges per plane, column 0 first.
REQ-020 rgb bit n of a channel = bit (plane) of that channel's COLOUR_DEPTH-bit value; plane 0 = LSB.
REQ-021 oe_n_out SHALL be high throughout SHIFT and LATCH.
REQ-022 LATCH: bclk_out low, latch_out high for BCLK_DIV cycles; row_addr_out updated to the shifted row on the first LATCH cycle.
REQ-023 DISPLAY: oe_n_out low for exactly BASE_ON_CYCLES << plane cycles (width RA+CA+COLOUR_DEPTH+clog2(BASE_ON_CYCLES) counter, no overflow).
REQ-024 After DISPLAY: plane increments; after plane COLOUR_DEPTH-1, plane=0 and row increments; after last row, row wraps to 0 and frame_done_out pulses in the cycle DISPLAY ends.
REQ-025 enable_in sampled only at DISPLAY end; low -> IDLE with oe_n_out high; mid-plane deassertion never truncates SHIFT, LATCH or DISPLAY.
REQ-026 Re-enable from IDLE restarts at row 0, plane 0.
REQ-027 rd_data_in is ignored in all states except the capture cycle of SHIFT.

Reset
REQ-028 n_reset_in low SHALL immediately force: state IDLE, oe_n_out=1, bclk_out=0, latch_out=0, rgb_top_out=0, rgb_bot_out=0, row_addr_out=0, rd_addr_out=0, frame_done_out=0, all counters 0.
REQ-029 Reset asserted mid-SHIFT/LATCH/DISPLAY SHALL abort the plane; on release, scanning restarts from row 0, plane 0 if enable_in=1.

Configuration
REQ-030 Macro LED_DISPLAY_BRIGHTNESS_EN defined: adds input brightness_in [7:0]; in DISPLAY, oe_n_out low only for the first ((BASE_ON_CYCLES<<plane)*(brightness_in+1))>>8 cycles, high for the remainder; DISPLAY duration unchanged; brightness_in sampled at DISPLAY entry.
REQ-031 Macro undefined: no brightness_in port; oe_n_out low for the full DISPLAY period (REQ-023).

Verification (NUM_ROW_PIXELS=8, NUM_COL_PIXELS=4, COLOUR_DEPTH=2, BCLK_DIV=1, BASE_ON_CYCLES=4)
REQ-032 Reset mid-DISPLAY -> all outputs at REQ-028 values within the same cycle; after release, rd_addr_out=0, row_addr_out=0.
REQ-033 Frame buffer pixel(row1,col2) top = R3,G0,B1 -> plane0 shift, col2: rgb_top_out=3'b101; plane1: 3'b001.
REQ-034 One plane -> exactly 4 bclk rising edges, then 1-cycle latch_out, then oe_n_out low 4 cycles (plane0), 8 cycles (plane1).
REQ-035 Continuous enable -> frame_done_out single pulse every 4 rows x 2 planes; row_addr_out sequence 0,1,2,3,0.
REQ-036 enable_in dropped mid-SHIFT -> plane completes full DISPLAY, then IDLE, oe_n_out=1, no further bclk edges.
REQ-037 LED_DISPLAY_BRIGHTNESS_EN, brightness_in=127, plane1 -> oe_n_out low 4 of 8 DISPLAY cycles; brightness_in=255 -> low all 8.

Source files
------------

// File: rtl/led_display_bcm_driver.sv
// Shift-register LED panel driver with binary-coded modulation over COLOUR_DEPTH bit planes.
// Optional global dimming enabled by defining LED_DISPLAY_BRIGHTNESS_EN (adds brightness_in).
module led_display_bcm_driver #(
   parameter int unsigned NUM_ROW_PIXELS = 32,
   parameter int unsigned NUM_COL_PIXELS = 64,
   parameter int unsigned COLOUR_DEPTH   = 8,
   parameter int unsigned BCLK_DIV       = 2,
   parameter int unsigned BASE_ON_CYCLES = 64,
   localparam int unsigned RA = ($clog2(NUM_ROW_PIXELS / 2) > 0) ? $clog2(NUM_ROW_PIXELS / 2) : 1,
   localparam int unsigned CA = ($clog2(NUM_COL_PIXELS) > 0) ? $clog2(NUM_COL_PIXELS) : 1
) (
   input  logic                      clk_in,
   input  logic                      n_reset_in,
   input  logic                      enable_in,
`ifdef LED_DISPLAY_BRIGHTNESS_EN
   input  logic [7:0]                brightness_in,
`endif
   output logic [RA+CA-1:0]          rd_addr_out,
   input  logic [6*COLOUR_DEPTH-1:0] rd_data_in,
   output logic [2:0]                rgb_top_out,
   output logic [2:0]                rgb_bot_out,
   output logic                      bclk_out,
   output logic                      latch_out,
   output logic                      oe_n_out,
   output logic [RA-1:0]             row_addr_out,
   output logic                      frame_done_out
);
   localparam int unsigned CD        = COLOUR_DEPTH;
   localparam int unsigned PW        = ($clog2(CD) > 0) ? $clog2(CD) : 1;
   localparam int unsigned DW        = ($clog2(BCLK_DIV) > 0) ? $clog2(BCLK_DIV) : 1;
   localparam int unsigned CW        = RA + CA + CD + $clog2(BASE_ON_CYCLES);
   localparam int unsigned SCAN_ROWS = NUM_ROW_PIXELS / 2;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_DISPLAY} state_e;
   typedef enum logic [1:0] {PH_WAIT, PH_CAP, PH_LOW, PH_HIGH} phase_e;

   state_e            state_q, state_d;
   phase_e            ph_q, ph_d;
   logic [DW-1:0]     div_q, div_d;
   logic [CA-1:0]     col_q, col_d;
   logic [RA-1:0]     row_q, row_d;
   logic [PW-1:0]     plane_q, plane_d;
   logic [CW-1:0]     disp_q, disp_d;
   logic [RA+CA-1:0]  rd_addr_q, rd_addr_d;
   logic [2:0]        rgb_top_q, rgb_top_d, rgb_bot_q, rgb_bot_d;
   logic              bclk_q, bclk_d, latch_q, latch_d, oe_n_q, oe_n_d, frame_q, frame_d;
   logic [RA-1:0]     row_addr_q, row_addr_d;

   logic [CD-1:0]     rt_c, gt_c, bt_c, rb_c, gb_c, bb_c;
   logic [CW-1:0]     dur_c, on_c, on_entry_c;
   logic [RA-1:0]     row_nx_c;
   logic [PW-1:0]     plane_nx_c;
   logic              last_div_c, last_col_c, last_plane_c, last_row_c, frame_last_c;

   assign rt_c = rd_data_in[6*CD-1 -: CD];
   assign gt_c = rd_data_in[5*CD-1 -: CD];
   assign bt_c = rd_data_in[4*CD-1 -: CD];
   assign rb_c = rd_data_in[3*CD-1 -: CD];
   assign gb_c = rd_data_in[2*CD-1 -: CD];
   assign bb_c = rd_data_in[CD-1:0];

   assign dur_c        = CW'(BASE_ON_CYCLES) << plane_q;
   assign last_div_c   = (div_q == DW'(BCLK_DIV - 1));
   assign last_col_c   = (col_q == CA'(NUM_COL_PIXELS - 1));
   assign last_plane_c = (plane_q == PW'(CD - 1));
   assign last_row_c   = (row_q == RA'(SCAN_ROWS - 1));
   assign frame_last_c = last_plane_c && last_row_c;

`ifdef LED_DISPLAY_BRIGHTNESS_EN
   localparam int unsigned PRW = CW + 9;
   logic [CW-1:0]  on_q, on_d;
   logic [PRW-1:0] prod_c;

   // Lit portion of the plane scales with brightness+1 over 256.
   assign prod_c     = PRW'(dur_c) * PRW'({1'b0, brightness_in} + 9'd1);
   assign on_entry_c = CW'(prod_c >> 8);
   assign on_c       = on_q;
`else
   assign on_entry_c = dur_c;
   assign on_c       = dur_c;
`endif

   // Plane/row position after the current plane's DISPLAY completes.
   always_comb begin
      plane_nx_c = plane_q + PW'(1);
      row_nx_c   = row_q;
      if (last_plane_c) begin
         plane_nx_c = '0;
         row_nx_c   = last_row_c ? '0 : row_q + RA'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      ph_d       = ph_q;
      div_d      = div_q;
      col_d      = col_q;
      row_d      = row_q;
      plane_d    = plane_q;
      disp_d     = disp_q;
      rd_addr_d  = rd_addr_q;
      rgb_top_d  = rgb_top_q;
      rgb_bot_d  = rgb_bot_q;
      bclk_d     = bclk_q;
      latch_d    = latch_q;
      oe_n_d     = oe_n_q;
      row_addr_d = row_addr_q;
      frame_d    = 1'b0;
`ifdef LED_DISPLAY_BRIGHTNESS_EN
      on_d       = on_q;
`endif
      case (state_q)
         S_IDLE: begin
            oe_n_d  = 1'b1;
            bclk_d  = 1'b0;
            latch_d = 1'b0;
            if (enable_in) begin
               state_d   = S_SHIFT;
               ph_d      = PH_WAIT;
               div_d     = '0;
               col_d     = '0;
               row_d     = '0;
               plane_d   = '0;
               rd_addr_d = '0;
            end
         end
         S_SHIFT: begin
            // Address is presented in WAIT; the frame buffer answers during CAP.
            case (ph_q)
               PH_WAIT: ph_d = PH_CAP;
               PH_CAP: begin
                  rgb_top_d = {bt_c[plane_q], gt_c[plane_q], rt_c[plane_q]};
                  rgb_bot_d = {bb_c[plane_q], gb_c[plane_q], rb_c[plane_q]};
                  ph_d      = PH_LOW;
                  div_d     = '0;
               end
               PH_LOW: begin
                  if (last_div_c) begin
                     bclk_d = 1'b1;
                     ph_d   = PH_HIGH;
                     div_d  = '0;
                  end else begin
                     div_d = div_q + DW'(1);
                  end
               end
               default: begin
                  if (last_div_c) begin
                     bclk_d = 1'b0;
                     div_d  = '0;
                     if (last_col_c) begin
                        state_d    = S_LATCH;
                        latch_d    = 1'b1;
                        row_addr_d = row_q;
                        col_d      = '0;
                     end else begin
                        col_d     = col_q + CA'(1);
                        rd_addr_d = {row_q, col_q + CA'(1)};
                        ph_d      = PH_WAIT;
                     end
                  end else begin
                     div_d = div_q + DW'(1);
                  end
               end
            endcase
         end
         S_LATCH: begin
            if (last_div_c) begin
               state_d = S_DISPLAY;
               latch_d = 1'b0;
               div_d   = '0;
               disp_d  = '0;
               oe_n_d  = (on_entry_c == '0);
               frame_d = frame_last_c && (dur_c == CW'(1));
`ifdef LED_DISPLAY_BRIGHTNESS_EN
               on_d    = on_entry_c;
`endif
            end else begin
               div_d = div_q + DW'(1);
            end
         end
         default: begin
            if (disp_q == dur_c - CW'(1)) begin
               oe_n_d  = 1'b1;
               disp_d  = '0;
               plane_d = plane_nx_c;
               row_d   = row_nx_c;
               // Enable is only honoured at a plane boundary.
               if (enable_in) begin
                  state_d   = S_SHIFT;
                  ph_d      = PH_WAIT;
                  col_d     = '0;
                  rd_addr_d = {row_nx_c, CA'(0)};
               end else begin
                  state_d   = S_IDLE;
                  row_d     = '0;
                  plane_d   = '0;
                  rd_addr_d = '0;
               end
            end else begin
               disp_d  = disp_q + CW'(1);
               oe_n_d  = !((disp_q + CW'(1)) < on_c);
               frame_d = frame_last_c && (({1'b0, disp_q} + (CW+1)'(2)) == {1'b0, dur_c});
            end
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge n_reset_in) begin
      if (!n_reset_in) begin
         state_q    <= S_IDLE;
         ph_q       <= PH_WAIT;
         div_q      <= '0;
         col_q      <= '0;
         row_q      <= '0;
         plane_q    <= '0;
         disp_q     <= '0;
         rd_addr_q  <= '0;
         rgb_top_q  <= '0;
         rgb_bot_q  <= '0;
         bclk_q     <= 1'b0;
         latch_q    <= 1'b0;
         oe_n_q     <= 1'b1;
         row_addr_q <= '0;
         frame_q    <= 1'b0;
`ifdef LED_DISPLAY_BRIGHTNESS_EN
         on_q       <= '0;
`endif
      end else begin
         state_q    <= state_d;
         ph_q       <= ph_d;
         div_q      <= div_d;
         col_q      <= col_d;
         row_q      <= row_d;
         plane_q    <= plane_d;
         disp_q     <= disp_d;
         rd_addr_q  <= rd_addr_d;
         rgb_top_q  <= rgb_top_d;
         rgb_bot_q  <= rgb_bot_d;
         bclk_q     <= bclk_d;
         latch_q    <= latch_d;
         oe_n_q     <= oe_n_d;
         row_addr_q <= row_addr_d;
         frame_q    <= frame_d;
`ifdef LED_DISPLAY_BRIGHTNESS_EN
         on_q       <= on_d;
`endif
      end
   end

   assign rd_addr_out    = rd_addr_q;
   assign rgb_top_out    = rgb_top_q;
   assign rgb_bot_out    = rgb_bot_q;
   assign bclk_out       = bclk_q;
   assign latch_out      = latch_q;
   assign oe_n_out       = oe_n_q;
   assign row_addr_out   = row_addr_q;
   assign frame_done_out = frame_q;

endmodule

// File: tb/tb_led_display_bcm_driver.sv
// Scoreboard bench for led_display_bcm_driver on a 8x4 panel, 2 bit planes, BCLK_DIV=1, BASE_ON_CYCLES=4.
module tb_led_display_bcm_driver;
   localparam int EV_BCLK  = 0;
   localparam int EV_LATCH = 1;
   localparam int EV_DISP  = 2;
   localparam int EV_FRAME = 3;

   typedef struct {
      int kind;
      int val;
   } ev_t;

   logic        clk = 1'b0;
   logic        n_reset;
   logic        enable;
   logic [3:0]  rd_addr_out;
   logic [11:0] rd_data;
   logic [2:0]  rgb_top_out, rgb_bot_out;
   logic        bclk_out, latch_out, oe_n_out, frame_done_out;
   logic [1:0]  row_addr_out;
`ifdef LED_DISPLAY_BRIGHTNESS_EN
   logic [7:0]  brightness;
`endif

   logic [11:0] mem [16];
   ev_t         exp_q [$];
   int          n_tests = 0;
   int          n_fail  = 0;

   logic prev_bclk, prev_latch, prev_oe;
   int   oe_run, latch_run, latch_bad, nbclk;

   led_display_bcm_driver #(
      .NUM_ROW_PIXELS(8), .NUM_COL_PIXELS(4), .COLOUR_DEPTH(2),
      .BCLK_DIV(1), .BASE_ON_CYCLES(4)
   ) dut (
      .clk_in(clk),
      .n_reset_in(n_reset),
      .enable_in(enable),
`ifdef LED_DISPLAY_BRIGHTNESS_EN
      .brightness_in(brightness),
`endif
      .rd_addr_out(rd_addr_out),
      .rd_data_in(rd_data),
      .rgb_top_out(rgb_top_out),
      .rgb_bot_out(rgb_bot_out),
      .bclk_out(bclk_out),
      .latch_out(latch_out),
      .oe_n_out(oe_n_out),
      .row_addr_out(row_addr_out),
      .frame_done_out(frame_done_out)
   );

   always #5 clk = ~clk;

   // Synchronous-read frame buffer: data one cycle after the address.
   always @(posedge clk) rd_data <= mem[rd_addr_out];

   function automatic string kname(input int k);
      case (k)
         EV_BCLK:  return "bclk_rgb";
         EV_LATCH: return "latch";
         EV_DISP:  return "display_on";
         default:  return "frame_done";
      endcase
   endfunction

   function automatic int exp_rgb(input int row, input int col, input int plane);
      logic [11:0] w;
      logic [5:0]  r;
      w = mem[row*4 + col];
      r = {w[6+plane], w[8+plane], w[10+plane], w[plane], w[2+plane], w[4+plane]};
      return int'(r);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic push_ev(input int kind, input int val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic push_plane(input int row, input int plane, input bit frame,
                             input bit with_disp, input int run);
      for (int c = 0; c < 4; c++) push_ev(EV_BCLK, 64 + exp_rgb(row, c, plane));
      push_ev(EV_LATCH, row*256 + 16 + 4);
      if (frame) push_ev(EV_FRAME, row);
      if (with_disp) push_ev(EV_DISP, run);
   endtask

   task automatic got_event(input int kind, input int val);
      ev_t e;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_%s: got val 'h%0h, required no event", kname(kind), val);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.val != val) begin
            n_fail++;
            $display("FAIL %s: got %s val 'h%0h, required %s val 'h%0h",
                     kname(e.kind), kname(kind), val, kname(e.kind), e.val);
         end
      end
   endtask

   task automatic wait_latches(input int n, input int budget);
      int   seen;
      logic prev;
      seen = 0;
      prev = latch_out;
      for (int c = 0; c < budget && seen < n; c++) begin
         @(negedge clk);
         if (latch_out && !prev) seen++;
         prev = latch_out;
      end
      chk("wait_latch_pulses", seen, n);
   endtask

   task automatic wait_drain(input string name, input int budget);
      for (int c = 0; c < budget && exp_q.size() != 0; c++) @(negedge clk);
      chk(name, exp_q.size(), 0);
   endtask

   // Monitor: turn panel activity into events and match them against the queue.
   always @(negedge clk) begin
      if (!n_reset) begin
         prev_bclk  = 1'b0;
         prev_latch = 1'b0;
         prev_oe    = 1'b1;
         oe_run     = 0;
         latch_run  = 0;
         latch_bad  = 0;
         nbclk      = 0;
      end else begin
         if (frame_done_out) got_event(EV_FRAME, int'(oe_n_out)*16 + int'(row_addr_out));
         if (bclk_out && !prev_bclk) begin
            nbclk++;
            got_event(EV_BCLK, int'({oe_n_out, rgb_top_out, rgb_bot_out}));
         end
         if (latch_out) begin
            latch_run++;
            if (!oe_n_out || bclk_out) latch_bad = 1;
         end else if (prev_latch) begin
            got_event(EV_LATCH, latch_bad*4096 + int'(row_addr_out)*256 + latch_run*16 + nbclk);
            latch_run = 0;
            latch_bad = 0;
            nbclk     = 0;
         end
         if (!oe_n_out) oe_run++;
         else if (!prev_oe) begin
            got_event(EV_DISP, oe_run);
            oe_run = 0;
         end
         prev_bclk  = bclk_out;
         prev_latch = latch_out;
         prev_oe    = oe_n_out;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      mem[0]  = 12'h000; mem[1]  = 12'hFFF; mem[2]  = 12'hA5A; mem[3]  = 12'h5A5;
      mem[4]  = 12'h123; mem[5]  = 12'h456; mem[6]  = 12'hC67; mem[7]  = 12'h789;
      mem[8]  = 12'hABC; mem[9]  = 12'hDEF; mem[10] = 12'h0F0; mem[11] = 12'hF0F;
      mem[12] = 12'h369; mem[13] = 12'h9C3; mem[14] = 12'h1E2; mem[15] = 12'h2D4;
      n_reset = 1'b0;
      enable  = 1'b0;
`ifdef LED_DISPLAY_BRIGHTNESS_EN
      brightness = 8'd255;
`endif
      repeat (3) @(negedge clk);
      chk("reset_oe_n", int'(oe_n_out), 1);
      chk("reset_bclk", int'(bclk_out), 0);
      chk("reset_latch", int'(latch_out), 0);
      chk("reset_rgb_top", int'(rgb_top_out), 0);
      chk("reset_rgb_bot", int'(rgb_bot_out), 0);
      chk("reset_row_addr", int'(row_addr_out), 0);
      chk("reset_rd_addr", int'(rd_addr_out), 0);
      chk("reset_frame_done", int'(frame_done_out), 0);
      n_reset = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_disabled_oe_n", int'(oe_n_out), 1);

      // One full frame plus row 0 again, enable dropped mid-SHIFT of row 0 plane 1.
      for (int r = 0; r < 4; r++)
         for (int p = 0; p < 2; p++)
            push_plane(r, p, (r == 3 && p == 1), 1'b1, 4 << p);
      push_plane(0, 0, 1'b0, 1'b1, 4);
      push_plane(0, 1, 1'b0, 1'b1, 8);
      enable = 1'b1;
      wait_latches(9, 400);
      repeat (10) @(negedge clk);
      enable = 1'b0;
      wait_drain("drain_after_disable", 200);
      repeat (40) @(negedge clk);
      chk("idle_after_disable_oe_n", int'(oe_n_out), 1);
      chk("idle_after_disable_events", exp_q.size(), 0);

      // Re-enable from IDLE restarts at row 0 plane 0; reset lands mid-DISPLAY.
      push_plane(0, 0, 1'b0, 1'b0, 0);
      enable = 1'b1;
      wait_latches(1, 100);
      repeat (2) @(negedge clk);
      #2 n_reset = 1'b0;
      #1;
      chk("midreset_oe_n", int'(oe_n_out), 1);
      chk("midreset_bclk", int'(bclk_out), 0);
      chk("midreset_latch", int'(latch_out), 0);
      chk("midreset_rgb_top", int'(rgb_top_out), 0);
      chk("midreset_rgb_bot", int'(rgb_bot_out), 0);
      chk("midreset_row_addr", int'(row_addr_out), 0);
      chk("midreset_rd_addr", int'(rd_addr_out), 0);
      chk("midreset_frame_done", int'(frame_done_out), 0);
      chk("midreset_events", exp_q.size(), 0);
      push_plane(0, 0, 1'b0, 1'b1, 4);
      repeat (3) @(negedge clk);
      n_reset = 1'b1;
      #1;
      chk("release_rd_addr", int'(rd_addr_out), 0);
      chk("release_row_addr", int'(row_addr_out), 0);
      @(negedge clk);
      chk("release_rd_addr_shift", int'(rd_addr_out), 0);
      wait_latches(1, 100);
      enable = 1'b0;
      wait_drain("drain_after_reset", 100);
      repeat (30) @(negedge clk);
      chk("idle_after_reset_events", exp_q.size(), 0);

`ifdef LED_DISPLAY_BRIGHTNESS_EN
      // Half brightness: plane 0 lit 2 of 4 cycles, plane 1 lit 4 of 8.
      brightness = 8'd127;
      push_plane(0, 0, 1'b0, 1'b1, 2);
      push_plane(0, 1, 1'b0, 1'b1, 4);
      enable = 1'b1;
      wait_latches(2, 200);
      enable = 1'b0;
      wait_drain("drain_brightness", 100);
      repeat (30) @(negedge clk);
      chk("idle_brightness_events", exp_q.size(), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
